// File: rtl/imm_gen_stage.sv
// imm_gen_stage: RISC-V immediate generator with a two-entry skid buffer.
// Ports: clk, reset (async, active-high), flush (sync kill),
//   in_valid/in_ready/in_instr/in_type/in_tag (upstream handshake),
//   out_valid/out_ready/out_imm/out_type/out_tag (downstream handshake).
// in_type: 000 none, 001 I, 010 S, 011 B, 100 U, 101 J, 110 Z, 111 SHAMT.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  imm_new;
    logic             in_fire;
    logic             load_out;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [2:0]       out_type_q, out_type_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [2:0]       skid_type_q, skid_type_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

    // Opcode bits never feed any immediate format.
    logic unused_opcode;
    assign unused_opcode = ^in_instr[6:0];

    // Sign extension via size cast of a signed operand.
    always_comb begin
        imm_new = '0;
        case (in_type)
            3'b001: imm_new = XLEN'($signed(in_instr[31:20]));
            3'b010: imm_new = XLEN'($signed({in_instr[31:25],
                                             in_instr[11:7]}));
            3'b011: imm_new = XLEN'($signed({in_instr[31], in_instr[7],
                                             in_instr[30:25],
                                             in_instr[11:8], 1'b0}));
            3'b100: imm_new = XLEN'($signed({in_instr[31:12], 12'b0}));
            3'b101: imm_new = XLEN'($signed({in_instr[31],
                                             in_instr[19:12],
                                             in_instr[20],
                                             in_instr[30:21], 1'b0}));
            3'b110: imm_new = XLEN'(in_instr[19:15]);
            3'b111: begin
                if (XLEN == 64) imm_new = XLEN'(in_instr[25:20]);
                else            imm_new = XLEN'(in_instr[24:20]);
            end
            default: imm_new = '0;
        endcase
    end

    // Ready only depends on skid occupancy, so it comes straight off a flop.
    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && in_ready;
    assign load_out = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_type_d   = out_type_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_type_d  = skid_type_q;
        skid_tag_d   = skid_tag_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (load_out) begin
            // Skid full implies in_ready low, so no input competes here.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_type_d   = skid_type_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_imm_d  = imm_new;
                    out_type_d = in_type;
                    out_tag_d  = in_tag;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = imm_new;
            skid_type_d  = in_type;
            skid_tag_d   = in_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_type_q   <= '0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_type_q  <= '0;
            skid_tag_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_type_q   <= out_type_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_type_q  <= skid_type_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_type  = out_type_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: checks XLEN=32 and XLEN=64 instances side by side
// against a queue-based reference model and fixed immediate vectors.
module tb_imm_gen_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_type;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        rdy32, vld32, rdy64, vld64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  typ32, typ64;
    logic [31:0] tag32, tag64;

    imm_gen_stage #(.XLEN(32), .TAG_W(32)) u32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag),
        .out_valid(vld32), .out_ready(out_ready),
        .out_imm(imm32), .out_type(typ32), .out_tag(tag32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(32)) u64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag),
        .out_valid(vld64), .out_ready(out_ready),
        .out_imm(imm64), .out_type(typ64), .out_tag(tag64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] tag;
        logic [2:0]  typ;
        logic [63:0] i32;
        logic [63:0] i64;
    } ent_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  typ;
        logic [63:0] e32;
        logic [63:0] e64;
    } vec_t;

    ent_t        q[$];
    logic [31:0] got[$];
    int          ncmp = 0;
    int          nfail = 0;

    function automatic longint sx(input longint v, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        return (v >= half) ? v - (half << 1) : v;
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins,
                                            input logic [2:0] t,
                                            input int xlen);
        longint u, v;
        u = ins;
        case (t)
            3'd1: v = sx(u >> 20, 12);
            3'd2: v = sx(((u >> 25) << 5) + ((u >> 7) & 31), 12);
            3'd3: v = sx(((u >> 31) << 12) + (((u >> 7) & 1) << 11)
                         + (((u >> 25) & 63) << 5)
                         + (((u >> 8) & 15) << 1), 13);
            3'd4: v = sx(u & 64'hFFFF_F000, 32);
            3'd5: v = sx(((u >> 31) << 20) + (((u >> 12) & 255) << 12)
                         + (((u >> 20) & 1) << 11)
                         + (((u >> 21) & 1023) << 1), 21);
            3'd6: v = (u >> 15) & 31;
            3'd7: v = (u >> 20) & ((xlen == 64) ? 63 : 31);
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return 64'(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("in_ready32", 64'(rdy32), 64'(q.size() < 2));
        chk("in_ready64", 64'(rdy64), 64'(q.size() < 2));
        chk("out_valid32", 64'(vld32), 64'(q.size() > 0));
        chk("out_valid64", 64'(vld64), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("imm32", 64'(imm32), q[0].i32);
            chk("imm64", imm64, q[0].i64);
            chk("type32", 64'(typ32), 64'(q[0].typ));
            chk("type64", 64'(typ64), 64'(q[0].typ));
            chk("tag32", 64'(tag32), 64'(q[0].tag));
            chk("tag64", 64'(tag64), 64'(q[0].tag));
        end
    endtask

    // Called just after a negedge; returns at the following negedge.
    task automatic step(input logic v, input logic [31:0] ins,
                        input logic [2:0] t, input logic [31:0] tg,
                        input logic ordy, input logic fl);
        ent_t e;
        bit   rdy, ovld;
        in_valid  = v;
        in_instr  = ins;
        in_type   = t;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        if (vld32 && ordy && !fl) got.push_back(tag32);
        @(posedge clk);
        rdy  = q.size() < 2;
        ovld = q.size() > 0;
        if (fl) begin
            q.delete();
        end else begin
            if (ovld && ordy) void'(q.pop_front());
            if (v && rdy) begin
                e.tag = tg;
                e.typ = t;
                e.i32 = ref_imm(ins, t, 32);
                e.i64 = ref_imm(ins, t, 64);
                q.push_back(e);
            end
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
    endtask

    vec_t vt[10];
    int   nexttag;
    int   cyc;
    bit   saw_low;

    initial begin
        vt[0] = '{32'hFFF00093, 3'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[1] = '{32'hFE000EE3, 3'd3, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC};
        vt[2] = '{32'h800000B7, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000};
        vt[3] = '{32'h123450B7, 3'd4, 64'h1234_5000, 64'h0000_0000_1234_5000};
        vt[4] = '{32'h03F00013, 3'd7, 64'h1F, 64'h3F};
        vt[5] = '{32'h000F8073, 3'd6, 64'h1F, 64'h1F};
        vt[6] = '{32'hFFFFFFFF, 3'd0, 64'h0, 64'h0};
        vt[7] = '{32'h00A12423, 3'd2, 64'h8, 64'h8};
        vt[8] = '{32'hFE000FA3, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[9] = '{32'hFFDFF06F, 3'd5, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC};

        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        in_type = '0;
        in_tag = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 64'(vld32 | vld64), 64'h0);
        chk("rst_in_ready", 64'(rdy32 & rdy64), 64'h1);
        chk("rst_imm", imm64 | 64'(imm32), 64'h0);
        chk("rst_type_tag", 64'(typ32 | typ64) | 64'(tag32 | tag64), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step(1'b1, vt[i].instr, vt[i].typ, 32'(i + 1), 1'b1, 1'b0);
            chk("vec_valid", 64'(vld32 & vld64), 64'h1);
            chk("vec_imm32", 64'(imm32), vt[i].e32);
            chk("vec_imm64", imm64, vt[i].e64);
        end
        idle(2);

        got.delete();
        nexttag = 1;
        saw_low = 0;
        cyc = 1;
        while (got.size() < 6 && cyc < 40) begin
            logic v;
            bit   acc;
            v   = nexttag <= 6;
            acc = v && (q.size() < 2);
            step(v, 32'hFFF00093, 3'd1, 32'(nexttag), !(cyc >= 2 && cyc <= 4),
                 1'b0);
            if (acc) nexttag++;
            if (!rdy32 && vld32) saw_low = 1;
            cyc++;
        end
        chk("seq_saw_in_ready_low", 64'(saw_low), 64'h1);
        chk("seq_count", 64'(got.size()), 64'd6);
        for (int i = 0; i < got.size() && i < 6; i++)
            chk("seq_order", 64'(got[i]), 64'(i + 1));
        idle(2);

        step(1'b1, 32'h123450B7, 3'd4, 32'd10, 1'b0, 1'b0);
        step(1'b1, 32'h800000B7, 3'd4, 32'd11, 1'b0, 1'b0);
        chk("full_in_ready", 64'(rdy32), 64'h0);
        step(1'b1, 32'hFFF00093, 3'd1, 32'd99, 1'b1, 1'b1);
        chk("flush_out_valid", 64'(vld32 | vld64), 64'h0);
        chk("flush_in_ready", 64'(rdy32 & rdy64), 64'h1);
        idle(3);

        step(1'b1, 32'h03F00013, 3'd7, 32'd20, 1'b0, 1'b0);
        step(1'b1, 32'h000F8073, 3'd6, 32'd21, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", 64'(vld32 | vld64), 64'h0);
        chk("arst_in_ready", 64'(rdy32 & rdy64), 64'h1);
        chk("arst_imm", imm64 | 64'(imm32), 64'h0);
        chk("arst_type_tag", 64'(typ32 | typ64) | 64'(tag32 | tag64), 64'h0);
        q.delete();
        #1 reset = 1'b0;
        step(1'b1, 32'hFE000EE3, 3'd3, 32'd55, 1'b1, 1'b0);
        chk("post_rst_tag", 64'(tag32), 64'd55);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
                 $urandom, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter XLEN, default 32, immediate width; legal values 32 and 64 only.
REQ-002 Parameter TAG_W, default 32, width of sideband tag (e.g. PC) carried alongside each instruction.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous kill of all buffered entries.
REQ-006 in_valid  input  1  input entry valid.
REQ-007 in_ready  output  1  stage can accept input this cycle.
REQ-008 in_instr  input  32  raw instruction word.
REQ-009 in_type  input  3  immediate format: 000 none, 001 I, 010 S, 011 B, 100 U, 101 J, 110 Z (CSR zimm), 111 SHAMT.
REQ-010 in_tag  input  TAG_W  sideband tag.
REQ-011 out_valid  output  1  output entry valid.
REQ-012 out_ready  input  1  downstream accepts output.
REQ-013 out_imm  output  XLEN  generated immediate.
REQ-014 out_type  output  3  in_type of the output entry.
REQ-015 out_tag  output  TAG_W  in_tag of the output entry.

Function
REQ-016 Formats: I = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); J = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}); sign bit is always instr[31], extended to XLEN.
REQ-017 U = {instr[31:12],12'b0}, sign-extended from bit 31 to XLEN when XLEN=64.
REQ-018 Z = zero-extended instr[19:15].
REQ-019 SHAMT = zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
REQ-020 Type 000 yields out_imm = 0; entry is still passed through.
REQ-021 Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-022 Storage: output register plus one skid register (2 entries total); latency in_valid transfer to out_valid = 1 cycle; sustained throughput 1 entry/cycle.
REQ-023 in_ready is driven directly from a flop: in_ready = !skid_valid.
REQ-024 Output empty or transferring: accepted entry loads the output register next cycle.
REQ-025 Output held (out_valid && !out_ready) and entry accepted: entry loads the skid register; in_ready deasserts next cycle.
REQ-026 Output transfers while skid holds: skid moves to the output register next cycle; in_ready reasserts.
REQ-027 Entries leave in acceptance order; no drop or duplicate under any out_ready pattern.
REQ-028 out_imm/out_type/out_tag hold stable while out_valid && !out_ready.
REQ-029 flush: next cycle out_valid=0 and skid empty, in_ready=1; an input presented in the flush cycle is discarded; flush overrides all simultaneous transfers.
REQ-030 The block does not check that in_type matches the instruction opcode.

Reset
REQ-031 reset assertion, at any time including mid-transfer, immediately clears out_valid and skid_valid; in_ready=1, out_imm=0, out_type=000, out_tag=0.
REQ-032 After reset release the first input is accepted on the first rising edge with in_valid=1.

Verification
REQ-033 XLEN=32, I, instr 0xFFF00093 (addi x1,x0,-1) -> out_imm 0xFFFFFFFF one cycle later; B, instr 0xFE000EE3 -> 0xFFFFFFFC.
REQ-034 XLEN=64, U, instr 0x800000B7 -> 0xFFFFFFFF80000000; U, 0x123450B7 -> 0x0000000012345000; SHAMT, instr[25:20]=0x3F -> 0x3F.
REQ-035 Z, instr[19:15]=5'b11111 -> out_imm 0x1F; type 000 with any instr -> 0.
REQ-036 Stream tags 1..6 back-to-back with out_ready=0 for cycles 2-4 -> in_ready low after two entries are held; outputs 1..6 in order, none lost.
REQ-037 Output and skid both full, flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle input never appears.
REQ-038 reset pulsed asynchronously mid-stream with skid full -> out_valid=0 and in_ready=1 before the next clock edge; normal flow resumes after release.
